// File: rtl/entry_point_arbiter_pkg.sv
// Shared definitions for the entry point arbiter: default widths, FSM state
// encodings and a small round-robin pointer helper.
// Optional feature macro: EPA_ZERO_ENTRY_CHECK_EN (zero entry point rejection).
package entry_point_arbiter_pkg;

    localparam int ROM_ADDRESS_WIDTH = 16;
    localparam int INSTRUCTION_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_PRESENT = 2'd3
    } epa_state_t;

    // Index of the requester after 'id', wrapping at 'n'.
    function automatic int wrap_inc(input int id, input int n);
        return (id >= n - 1) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/entry_point_arbiter_rr_priority_arbiter.sv
// Combinational round-robin winner selection: scans the request vector
// starting at 'ptr' and returns the first active requester as a one-hot
// grant plus its index.
module rr_priority_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   request,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] index,
    output logic           valid
);

    // Rotating priority scan; the first hit from ptr onward wins.
    always_comb begin : pick
        int j;
        grant = '0;
        index = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!valid && request[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                index    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/entry_point_arbiter.sv
// Entry point arbiter: grants one requester round-robin, reads its initial
// code address from instruction memory and offers the fetched entry point to
// the IFU until acknowledged.
// Handshake: oEntryValid stays high with oEntryPoint stable until a cycle with
// iIFU_Ack high; that cycle completes the transfer. iIFU_Ack is ignored in
// every other state.
// Optional feature macro: EPA_ZERO_ENTRY_CHECK_EN -- a fetched entry point of 0
// pulses oEntryError in CAPTURE and returns to IDLE without presenting.
module entry_point_arbiter
    import entry_point_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int AW      = ROM_ADDRESS_WIDTH,
    parameter int IW      = INSTRUCTION_WIDTH
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         iRequest,
    input  logic [NUM_REQ*AW-1:0]      iCodeAddress,
    output logic [NUM_REQ-1:0]         oGrant,
    output logic                       oIMemRead,
    output logic [AW-1:0]              oIMemAddr,
    input  logic [IW-1:0]              iIMemInput,
    output logic [AW-1:0]              oEntryPoint,
    output logic                       oEntryValid,
    input  logic                       iIFU_Ack,
    output logic [$clog2(NUM_REQ)-1:0] oRequesterId,
    output logic                       oBusy,
    output logic                       oEntryError,
    output epa_state_t                 oState
);

    localparam int IDW = $clog2(NUM_REQ);

    epa_state_t         state, next_state;
    logic [AW-1:0]      addr_q;
    logic [AW-1:0]      entry_q;
    logic [IDW-1:0]     id_q;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     next_ptr;
    logic [IDW-1:0]     win_idx;
    logic [NUM_REQ-1:0] win_grant;
    logic               win_valid;
    logic               zero_entry;
    logic               unused_imem_bits;

    rr_priority_arbiter #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_arb (
        .request (iRequest),
        .ptr     (rr_ptr),
        .grant   (win_grant),
        .index   (win_idx),
        .valid   (win_valid)
    );

    // Only the low AW bits of an instruction word carry the entry point.
    assign unused_imem_bits = ^iIMemInput[IW-1:AW];

    assign next_ptr = IDW'(wrap_inc(int'(id_q), NUM_REQ));

`ifdef EPA_ZERO_ENTRY_CHECK_EN
    assign zero_entry = (iIMemInput[AW-1:0] == '0);
`else
    assign zero_entry = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state and Moore/Mealy outputs; grant is masked while in reset.
    always_comb begin
        next_state  = state;
        oGrant      = '0;
        oIMemRead   = 1'b0;
        oIMemAddr   = '0;
        oEntryValid = 1'b0;
        oEntryError = 1'b0;
        oBusy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (Reset) oGrant = win_grant;
                if (win_valid) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                oIMemRead  = 1'b1;
                oIMemAddr  = addr_q;
                next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                oEntryError = zero_entry;
                next_state  = zero_entry ? ST_IDLE : ST_PRESENT;
            end
            ST_PRESENT: begin
                oEntryValid = 1'b1;
                if (iIFU_Ack) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Transaction datapath: latch winner, capture entry point, advance pointer.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            addr_q  <= '0;
            id_q    <= '0;
            entry_q <= '0;
            rr_ptr  <= '0;
        end else begin
            if (state == ST_IDLE && win_valid) begin
                addr_q <= iCodeAddress[int'(win_idx)*AW +: AW];
                id_q   <= win_idx;
            end
            if (state == ST_CAPTURE) begin
                entry_q <= iIMemInput[AW-1:0];
            end
            if ((state == ST_PRESENT && iIFU_Ack) || (state == ST_CAPTURE && zero_entry)) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    assign oEntryPoint  = entry_q;
    assign oRequesterId = id_q;
    assign oState       = state;

endmodule
